// File: rtl/fir_pkg.sv
// Widths and the requantise/saturate helper shared by the FIR stage and its output stage.
package fir_pkg;

   localparam int FIR_OUT_W = 32;
   localparam int SAMPLE_W  = 16;
   localparam int REQ_W     = FIR_OUT_W + 1;

   typedef struct packed {
      logic                       clip;
      logic signed [SAMPLE_W-1:0] data;
   } req_t;

   // Round half toward +inf, drop 'shift' LSBs, clamp to SAMPLE_W. One guard bit keeps the add from wrapping.
   function automatic req_t requant(input logic signed [FIR_OUT_W-1:0] x, input int unsigned shift);
      logic signed [REQ_W-1:0] wide;
      logic signed [REQ_W-1:0] bias;
      logic signed [REQ_W-1:0] r;
      logic signed [REQ_W-1:0] max_v;
      logic signed [REQ_W-1:0] min_v;
      req_t                    res;
      wide    = {x[FIR_OUT_W-1], x};
      bias    = '0;
      bias[0] = 1'b1;
      bias    = bias << (shift - 1);
      r       = (wide + bias) >>> shift;
      max_v   = {{(REQ_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
      min_v   = {{(REQ_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
      res.clip = (r > max_v) || (r < min_v);
      if (r > max_v)      res.data = max_v[SAMPLE_W-1:0];
      else if (r < min_v) res.data = min_v[SAMPLE_W-1:0];
      else                res.data = r[SAMPLE_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         wr_en;
   logic         rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage has no reset; empty gates dout, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/fir_decim_requant.sv
// FIR output stage: decimate, requantise/saturate, buffer, valid/ready out.
// Optional DROP_CNT_EN adds a saturating count of samples dropped on a full FIFO.
module fir_decim_requant
   import fir_pkg::*;
#(
   parameter int DATA_IN_W  = FIR_OUT_W,
   parameter int DATA_OUT_W = SAMPLE_W,
   parameter int DECIM      = 4,
   parameter int SHIFT      = 10,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_IN_W-1:0]  in_data,
   input  logic                  clear,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_OUT_W-1:0] out_data,
   output logic                  sat,
   output logic                  overflow
`ifdef DROP_CNT_EN
   ,
   output logic [15:0]           drop_cnt
`endif
);

   localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic [PH_W-1:0]       phase;
   logic                  keep;
   req_t                  req;
   logic                  s1_valid;
   logic [DATA_OUT_W-1:0] s1_data;
   logic                  full;
   logic                  empty;
   logic                  pop;
   logic                  drop;

   assign keep = in_valid && (phase == '0);
   assign req  = requant(in_data, SHIFT);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= '0;
      end else if (in_valid) begin
         phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= keep;
         if (keep) s1_data <= req.data;
      end
   end

   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign drop      = s1_valid && full && !pop;

   sync_fifo #(
      .W     (DATA_OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s1_valid),
      .pop   (pop),
      .din   (s1_data),
      .dout  (out_data),
      .full  (full),
      .empty (empty)
   );

   // Sticky flags: a new event in the same cycle as clear takes priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat      <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (keep && req.clip) sat <= 1'b1;
         else if (clear)       sat <= 1'b0;
         if (drop)             overflow <= 1'b1;
         else if (clear)       overflow <= 1'b0;
      end
   end

`ifdef DROP_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt <= '0;
      end else if (clear) begin
         drop_cnt <= drop ? 16'd1 : 16'd0;
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fir_decim_requant.sv
// Self-checking bench for fir_decim_requant: directed scenarios plus a randomized run against a queue model.
module tb_fir_decim_requant;

   localparam int DECIM = 4;
   localparam int SHIFT = 10;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        clear;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        sat;
   logic        overflow;
`ifdef DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fir_decim_requant #(
      .DATA_IN_W  (32),
      .DATA_OUT_W (16),
      .DECIM      (DECIM),
      .SHIFT      (SHIFT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clear     (clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sat       (sat),
      .overflow  (overflow)
`ifdef DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   // Reference requantiser from plain integer arithmetic.
   function automatic logic [15:0] ref_requant(input logic [31:0] x, output bit clip);
      longint v;
      longint r;
      v    = longint'($signed(x));
      r    = (v + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      clip = (r > 32767) || (r < -32768);
      if (r > 32767)       r = 32767;
      else if (r < -32768) r = -32768;
      return 16'(r);
   endfunction

   task automatic drive(input logic v, input logic [31:0] d, input logic rdy, input logic clr);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      clear     = clr;
   endtask

   task automatic do_reset();
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
         @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset.out_valid got=%b exp=0", out_valid); end
         n_tests++;
         if (out_data !== 16'd0) begin n_fail++; $display("FAIL reset.out_data got=%h exp=0", out_data); end
         n_tests++;
         if (sat !== 1'b0) begin n_fail++; $display("FAIL reset.sat got=%b exp=0", sat); end
         n_tests++;
         if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset.overflow got=%b exp=0", overflow); end
`ifdef DROP_CNT_EN
         n_tests++;
         if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset.drop_cnt got=%0d exp=0", drop_cnt); end
`endif
      end
   endtask

   task automatic test_decimation();
      bit exp_v;
      do_reset();
      drive(1'b1, 32'd2048, 1'b1, 1'b0);
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         exp_v = (c >= 1) && ((c - 1) % DECIM == 0);
         n_tests++;
         if (out_valid !== exp_v) begin n_fail++; $display("FAIL decim.out_valid cyc=%0d got=%b exp=%b", c, out_valid, exp_v); end
         if (exp_v) begin
            n_tests++;
            if (out_data !== 16'd2) begin n_fail++; $display("FAIL decim.out_data cyc=%0d got=%0d exp=2", c, out_data); end
         end
      end
      drive(1'b0, 32'd0, 1'b1, 1'b0);
   endtask

   task automatic test_rounding();
      logic [31:0] vals [4];
      logic [15:0] exps [4];
      vals = '{32'd1536, -32'sd1536, 32'd511, -32'sd512};
      exps = '{16'd2, 16'hFFFF, 16'd0, 16'd0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, vals[i], 1'b0, 1'b0);
         @(negedge clk);
         repeat (3) begin
            drive(1'b1, $urandom, 1'b0, 1'b0);
            @(negedge clk);
         end
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL round.out_valid idx=%0d got=%b exp=1", i, out_valid); end
         n_tests++;
         if (out_data !== exps[i]) begin n_fail++; $display("FAIL round.out_data idx=%0d got=%h exp=%h", i, out_data, exps[i]); end
         drive(1'b0, 32'd0, 1'b1, 1'b0);
         @(negedge clk);
      end
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL round.drained got=%b exp=0", out_valid); end
      n_tests++;
      if (sat !== 1'b0) begin n_fail++; $display("FAIL round.sat got=%b exp=0", sat); end
   endtask

   task automatic test_saturation();
      logic [15:0] got [$];
      logic [31:0] d;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         d = (c < 4) ? 32'h7FFF_FFFF : 32'h8000_0000;
         drive(c < 8, d, 1'b1, 1'b0);
         @(negedge clk);
         if (out_valid) got.push_back(out_data);
      end
      n_tests++;
      if (got.size() != 2) begin n_fail++; $display("FAIL sat.count got=%0d exp=2", got.size()); end
      if (got.size() >= 2) begin
         n_tests++;
         if (got[0] !== 16'h7FFF) begin n_fail++; $display("FAIL sat.max got=%h exp=7fff", got[0]); end
         n_tests++;
         if (got[1] !== 16'h8000) begin n_fail++; $display("FAIL sat.min got=%h exp=8000", got[1]); end
      end
      n_tests++;
      if (sat !== 1'b1) begin n_fail++; $display("FAIL sat.flag got=%b exp=1", sat); end
      drive(1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      n_tests++;
      if (sat !== 1'b0) begin n_fail++; $display("FAIL sat.clear got=%b exp=0", sat); end
      drive(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      @(negedge clk);
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      n_tests++;
      if (sat !== 1'b1) begin n_fail++; $display("FAIL sat.set_beats_clear got=%b exp=1", sat); end
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL sat.overflow got=%b exp=0", overflow); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         drive(1'b1, 32'(k * 1024), 1'b0, 1'b0);
         @(negedge clk);
         drive(1'b0, $urandom, 1'b0, 1'b0);
         @(negedge clk);
         repeat (3) begin
            drive(1'b1, $urandom, 1'b0, 1'b0);
            @(negedge clk);
         end
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      n_tests++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp.overflow got=%b exp=1", overflow); end
      n_tests++;
      if (sat !== 1'b0) begin n_fail++; $display("FAIL bp.sat got=%b exp=0", sat); end
`ifdef DROP_CNT_EN
      n_tests++;
      if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL bp.drop_cnt got=%0d exp=1", drop_cnt); end
`endif
      for (int i = 1; i <= 8; i++) begin
         n_tests++;
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp.out_valid idx=%0d got=%b exp=1", i, out_valid); end
         n_tests++;
         if (out_data !== 16'(i)) begin n_fail++; $display("FAIL bp.out_data idx=%0d got=%0d exp=%0d", i, out_data, i); end
         drive(1'b0, 32'd0, 1'b1, 1'b0);
         @(negedge clk);
      end
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp.drained got=%b exp=0", out_valid); end
      drive(1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp.clear got=%b exp=0", overflow); end
`ifdef DROP_CNT_EN
      n_tests++;
      if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL bp.drop_cnt_clear got=%0d exp=0", drop_cnt); end
`endif
   endtask

   task automatic test_reset_midstream();
      bit found;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 32'(k * 1024), 1'b0, 1'b0);
         @(negedge clk);
         repeat (3) begin
            drive(1'b1, $urandom, 1'b0, 1'b0);
            @(negedge clk);
         end
      end
      repeat (2) begin
         drive(1'b1, $urandom, 1'b0, 1'b0);
         @(negedge clk);
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst.queued got=%b exp=1", out_valid); end
      rst = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst.async_clear got=%b exp=0", out_valid); end
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 32'(7 * 1024), 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
         if (out_valid) found = 1'b1;
         else @(negedge clk);
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL midrst.timeout got=no_output exp=output");
      end else if (out_data !== 16'd7) begin
         n_fail++;
         $display("FAIL midrst.first_new got=%0d exp=7", out_data);
      end
   endtask

   task automatic test_random();
      logic [15:0] q [$];
      bit          m_s1v;
      logic [15:0] m_s1d;
      int          m_ph;
      bit          m_sat;
      bit          m_ovf;
      int          m_drop;
      bit          v, rdy, clr, pop, acc, drp, keep, clip;
      logic [31:0] d;
      logic [15:0] d_ref;
      int          sel;
      do_reset();
      m_s1v = 0; m_s1d = '0; m_ph = 0; m_sat = 0; m_ovf = 0; m_drop = 0;
      for (int c = 0; c < 1500; c++) begin
         n_tests++;
         if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand.out_valid cyc=%0d got=%b exp=%b", c, out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            n_tests++;
            if (out_data !== q[0]) begin n_fail++; $display("FAIL rand.out_data cyc=%0d got=%h exp=%h", c, out_data, q[0]); end
         end
         n_tests++;
         if (sat !== m_sat) begin n_fail++; $display("FAIL rand.sat cyc=%0d got=%b exp=%b", c, sat, m_sat); end
         n_tests++;
         if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand.overflow cyc=%0d got=%b exp=%b", c, overflow, m_ovf); end
`ifdef DROP_CNT_EN
         n_tests++;
         if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL rand.drop_cnt cyc=%0d got=%0d exp=%0d", c, drop_cnt, m_drop); end
`endif
         v   = ($urandom_range(0, 4) != 0);
         rdy = (c < 700) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 4) != 0);
         clr = ($urandom_range(0, 31) == 0);
         sel = $urandom_range(0, 9);
         if (sel == 0)      d = 32'h7FFF_FFFF;
         else if (sel == 1) d = 32'h8000_0000;
         else if (sel < 5)  d = $urandom;
         else               d = 32'($urandom_range(0, 32'h01FF_FFFF)) - 32'h0100_0000;
         drive(v, d, rdy, clr);

         pop  = (q.size() != 0) && rdy;
         acc  = m_s1v && ((q.size() < DEPTH) || pop);
         drp  = m_s1v && !acc;
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(m_s1d);
         keep  = v && (m_ph == 0);
         d_ref = ref_requant(d, clip);
         if (keep && clip) m_sat = 1;
         else if (clr)     m_sat = 0;
         if (drp)          m_ovf = 1;
         else if (clr)     m_ovf = 0;
         if (clr)                         m_drop = drp ? 1 : 0;
         else if (drp && m_drop < 65535)  m_drop++;
         m_s1v = keep;
         if (keep) m_s1d = d_ref;
         if (v) m_ph = (m_ph + 1) % DECIM;
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      test_reset();
      test_decimation();
      test_rounding();
      test_saturation();
      test_backpressure();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
